// File: rtl/adc_spi_tx.sv
// Frame-level SPI transmitter: serialises WORDS x WORD_BITS MSB first on CS/SCK/data.
// Optional feature: define ADC_TX_CHECKSUM_EN to append a mod-2^WORD_BITS sum word.
module adc_spi_tx #(
    parameter int WORDS       = 5,
    parameter int WORD_BITS   = 16,
    parameter int HALF_PERIOD = 18
) (
    input  logic                       i_Clock,
    input  logic                       i_Reset,
    input  logic                       i_Start,
    input  logic [WORDS*WORD_BITS-1:0] i_Data,
    output logic                       o_Busy,
    output logic                       o_Done,
    output logic                       o_ADC_CS,
    output logic                       o_ADC_Clock,
    output logic                       o_ADC_Data
);

`ifdef ADC_TX_CHECKSUM_EN
    localparam int TOTAL_WORDS = WORDS + 1;
`else
    localparam int TOTAL_WORDS = WORDS;
`endif
    localparam int TOTAL_BITS = TOTAL_WORDS * WORD_BITS;
    localparam int HP_W       = $clog2(HALF_PERIOD);
    localparam int BC_W       = $clog2(TOTAL_BITS + 1);
    localparam logic [HP_W-1:0] HP_RELOAD = HP_W'(HALF_PERIOD - 1);
    localparam logic [BC_W-1:0] BC_LOAD   = BC_W'(TOTAL_BITS);

    typedef enum logic [2:0] {S_IDLE, S_LEAD, S_LOW, S_HIGH, S_GUARD} state_t;

    state_t                state_q, state_d;
    logic [HP_W-1:0]       half_q, half_d;
    logic [BC_W-1:0]       bits_q, bits_d;
    logic [TOTAL_BITS-1:0] shift_q, shift_d;
    logic [TOTAL_BITS-1:0] frame;
    logic                  cs_q, cs_d;
    logic                  sck_q, sck_d;
    logic                  data_q, data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  expired;
`ifdef ADC_TX_CHECKSUM_EN
    logic [WORD_BITS-1:0]  checksum;
`endif

    // Word 0 lands in the top bits so the shift register always sends its MSB next.
    always_comb begin
        frame = '0;
        for (int p = 0; p < WORDS; p++) begin
            frame[TOTAL_BITS-1-p*WORD_BITS -: WORD_BITS] = i_Data[p*WORD_BITS +: WORD_BITS];
        end
`ifdef ADC_TX_CHECKSUM_EN
        checksum = '0;
        for (int p = 0; p < WORDS; p++) begin
            checksum = checksum + i_Data[p*WORD_BITS +: WORD_BITS];
        end
        frame[WORD_BITS-1:0] = checksum;
`endif
    end

    assign expired = (half_q == '0);

    always_comb begin
        state_d = state_q;
        half_d  = expired ? half_q : half_q - HP_W'(1);
        bits_d  = bits_q;
        shift_d = shift_q;
        cs_d    = cs_q;
        sck_d   = sck_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                half_d = '0;
                if (i_Start) begin
                    shift_d = frame;
                    bits_d  = BC_LOAD;
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    half_d  = HP_RELOAD;
                    state_d = S_LEAD;
                end
            end
            S_LEAD: begin
                if (expired) begin
                    sck_d   = 1'b0;
                    data_d  = shift_q[TOTAL_BITS-1];
                    half_d  = HP_RELOAD;
                    state_d = S_LOW;
                end
            end
            S_LOW: begin
                if (expired) begin
                    sck_d   = 1'b1;
                    half_d  = HP_RELOAD;
                    state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                if (expired) begin
                    sck_d  = 1'b0;
                    half_d = HP_RELOAD;
                    // Data only moves on the falling edge, so the next bit is driven here.
                    if (bits_q != BC_W'(1)) begin
                        shift_d = shift_q << 1;
                        bits_d  = bits_q - BC_W'(1);
                        data_d  = shift_q[TOTAL_BITS-2];
                        state_d = S_LOW;
                    end else begin
                        bits_d  = '0;
                        data_d  = 1'b0;
                        cs_d    = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_GUARD;
                    end
                end
            end
            S_GUARD: begin
                if (expired) begin
                    busy_d  = 1'b0;
                    half_d  = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q <= S_IDLE;
            half_q  <= '0;
            bits_q  <= '0;
            shift_q <= '0;
            cs_q    <= 1'b1;
            sck_q   <= 1'b0;
            data_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
            bits_q  <= bits_d;
            shift_q <= shift_d;
            cs_q    <= cs_d;
            sck_q   <= sck_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_Busy      = busy_q;
    assign o_Done      = done_q;
    assign o_ADC_CS    = cs_q;
    assign o_ADC_Clock = sck_q;
    assign o_ADC_Data  = data_q;

endmodule

// File: tb/tb_adc_spi_tx.sv
// Bench for adc_spi_tx: three configurations checked every cycle against a timing model.
// Honours ADC_TX_CHECKSUM_EN when it is defined for the whole build.
module tb_adc_spi_tx;

    localparam int WB = 16;
`ifdef ADC_TX_CHECKSUM_EN
    localparam int CKS = 1;
    localparam int CSLOW_A = 3474;
    localparam int BUSY_A  = 3492;
    localparam int CSLOW_B = 386;
    localparam int CSLOW_C = 195;
`else
    localparam int CKS = 0;
    localparam int CSLOW_A = 2898;
    localparam int BUSY_A  = 2916;
    localparam int CSLOW_B = 322;
    localparam int CSLOW_C = 99;
`endif
    localparam int HP[3] = '{18, 2, 3};
    localparam int NW[3] = '{5, 5, 1};

    logic        clock = 1'b0;
    logic        rst[3];
    logic        start[3];
    logic [79:0] data[3];
    logic        cs[3], sck[3], dat[3], busy[3], done[3];

    int  tests = 0;
    int  failures = 0;
    bit  checking = 1'b0;

    bit  active[3];
    int  jj[3];
    bit  txb[3][96];

    int          csLowLen[3], busyLen[3], doneCnt[3], csHighLen[3], lastGap[3], csFalls[3];
    int          rxBitCnt[3], rxWordCnt[3];
    logic [15:0] rxShift[3];
    logic [15:0] rxWords[3][8];
    bit          prevCs[3] = '{1'b1, 1'b1, 1'b1};
    bit          prevSck[3];
    bit          prevBusy[3];

    logic [15:0] expA[6] = '{16'h007B, 16'h0067, 16'h01FA, 16'h0000, 16'h0000, 16'h02DC};

    always #5 clock = ~clock;

    adc_spi_tx #(.WORDS(5), .WORD_BITS(16), .HALF_PERIOD(18)) dutA (
        .i_Clock(clock), .i_Reset(rst[0]), .i_Start(start[0]), .i_Data(data[0]),
        .o_Busy(busy[0]), .o_Done(done[0]), .o_ADC_CS(cs[0]),
        .o_ADC_Clock(sck[0]), .o_ADC_Data(dat[0]));

    adc_spi_tx #(.WORDS(5), .WORD_BITS(16), .HALF_PERIOD(2)) dutB (
        .i_Clock(clock), .i_Reset(rst[1]), .i_Start(start[1]), .i_Data(data[1]),
        .o_Busy(busy[1]), .o_Done(done[1]), .o_ADC_CS(cs[1]),
        .o_ADC_Clock(sck[1]), .o_ADC_Data(dat[1]));

    adc_spi_tx #(.WORDS(1), .WORD_BITS(16), .HALF_PERIOD(3)) dutC (
        .i_Clock(clock), .i_Reset(rst[2]), .i_Start(start[2]), .i_Data(data[2][15:0]),
        .o_Busy(busy[2]), .o_Done(done[2]), .o_ADC_CS(cs[2]),
        .o_ADC_Clock(sck[2]), .o_ADC_Data(dat[2]));

    function automatic int nbits(input int d);
        return (NW[d] + CKS) * WB;
    endfunction

    // Expected {cs,sck,data,busy,done} from the cycle offset j since the start edge.
    function automatic logic [4:0] expOut(input int d);
        int j, h, csLow, m, ph;
        if (!active[d]) return 5'b10000;
        j = jj[d];
        h = HP[d];
        csLow = h * (1 + 2 * nbits(d));
        if (j < h) return 5'b00010;
        if (j < csLow) begin
            m  = j - h;
            ph = m % (2 * h);
            return {1'b0, ph >= h, txb[d][m / (2 * h)], 1'b1, 1'b0};
        end
        return {1'b1, 1'b0, 1'b0, 1'b1, j == csLow};
    endfunction

    // Reference model: tracks frame acceptance and the bit list of the frame in flight.
    initial forever begin
        @(posedge clock);
        for (int d = 0; d < 3; d++) begin
            if (rst[d]) begin
                active[d] = 1'b0;
            end else if (!active[d]) begin
                if (start[d]) begin
                    logic [15:0] w;
                    int          sum;
                    sum = 0;
                    for (int p = 0; p < NW[d]; p++) begin
                        w = data[d][p*WB +: WB];
                        sum = sum + int'(w);
                        for (int i = 0; i < WB; i++) txb[d][p*WB+i] = w[WB-1-i];
                    end
                    w = 16'(sum);
                    for (int i = 0; i < WB * CKS; i++) txb[d][NW[d]*WB+i] = w[WB-1-i];
                    active[d] = 1'b1;
                    jj[d] = 0;
                end
            end else begin
                jj[d]++;
                if (jj[d] == HP[d] * (2 + 2 * nbits(d))) active[d] = 1'b0;
            end
        end
    end

    // Per-cycle comparison of every DUT against the model.
    initial forever begin
        @(negedge clock);
        if (checking) begin
            for (int d = 0; d < 3; d++) begin
                logic [4:0] got, expv;
                got  = {cs[d], sck[d], dat[d], busy[d], done[d]};
                expv = expOut(d);
                tests++;
                if (got !== expv) begin
                    failures++;
                    $display("[TB] FAIL cycleCompare dut%0d at %0t: got %b, expected %b (cs,sck,data,busy,done)",
                             d, $time, got, expv);
                end
            end
        end
    end

    // Receiver and timing monitor: samples data on SCK rise, measures CS/Busy spans.
    initial forever begin
        @(negedge clock);
        for (int d = 0; d < 3; d++) begin
            if (cs[d] === 1'b0) begin
                if (prevCs[d]) begin
                    lastGap[d]   = csHighLen[d];
                    csLowLen[d]  = 0;
                    rxBitCnt[d]  = 0;
                    rxWordCnt[d] = 0;
                    csFalls[d]++;
                end
                csLowLen[d]++;
                if (sck[d] === 1'b1 && !prevSck[d]) begin
                    rxShift[d] = {rxShift[d][14:0], dat[d]};
                    rxBitCnt[d]++;
                    if (rxBitCnt[d] % WB == 0 && rxWordCnt[d] < 8) begin
                        rxWords[d][rxWordCnt[d]] = rxShift[d];
                        rxWordCnt[d]++;
                    end
                end
            end else begin
                if (!prevCs[d]) csHighLen[d] = 0;
                csHighLen[d]++;
            end
            if (busy[d] === 1'b1 && !prevBusy[d]) busyLen[d] = 0;
            if (busy[d] === 1'b1) busyLen[d]++;
            if (done[d] === 1'b1) doneCnt[d]++;
            prevCs[d]   = (cs[d] !== 1'b0);
            prevSck[d]  = (sck[d] === 1'b1);
            prevBusy[d] = (busy[d] === 1'b1);
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic applyStimulus(input int d, input logic s, input logic [79:0] v);
        start[d] = s;
        data[d]  = v;
    endtask

    task automatic checkOutput(input string name, input int got, input int expv);
        tests++;
        if (got != expv) begin
            failures++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, expv, expv);
        end
    endtask

    task automatic waitIdle(input int d, input int limit, input string name);
        int n;
        n = 0;
        while (busy[d] !== 1'b0 && n < limit) begin
            tick();
            n++;
        end
        if (n >= limit) checkOutput({name, "Timeout"}, 0, 1);
    endtask

    function automatic logic [79:0] randData();
        return 80'({$urandom(), $urandom(), $urandom()});
    endfunction

    initial begin
        logic [79:0] vec, rd;
        int          fallsStart, n, doneBefore, sum;

        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1;
            applyStimulus(d, 1'b0, '0);
        end
        @(posedge clock);
        #1 checking = 1'b1;
        repeat (2) tick();
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;
        checkOutput("resetOutputsA", int'({cs[0], sck[0], dat[0], busy[0], done[0]}), 5'b10000);

        // Directed frame on all three configurations, plus an ignored mid-frame start.
        vec = {16'h0000, 16'h0000, 16'h01FA, 16'h0067, 16'h007B};
        for (int d = 0; d < 3; d++) doneCnt[d] = 0;
        applyStimulus(0, 1'b1, vec);
        applyStimulus(1, 1'b1, vec);
        applyStimulus(2, 1'b1, 80'h8001);
        tick();
        for (int d = 0; d < 3; d++) start[d] = 1'b0;
        repeat (100) tick();
        applyStimulus(0, 1'b1, randData());
        tick();
        applyStimulus(0, 1'b0, randData());
        waitIdle(0, 4000, "frameA");
        checkOutput("csLowA", csLowLen[0], CSLOW_A);
        checkOutput("busyA", busyLen[0], BUSY_A);
        checkOutput("doneCountA", doneCnt[0], 1);
        checkOutput("wordCountA", rxWordCnt[0], NW[0] + CKS);
        for (int p = 0; p < NW[0] + CKS; p++) checkOutput($sformatf("rxWordA%0d", p), int'(rxWords[0][p]), int'(expA[p]));
        checkOutput("csLowB", csLowLen[1], CSLOW_B);
        for (int p = 0; p < NW[1] + CKS; p++) checkOutput($sformatf("rxWordB%0d", p), int'(rxWords[1][p]), int'(expA[p]));
        checkOutput("csLowC", csLowLen[2], CSLOW_C);
        for (int p = 0; p < NW[2] + CKS; p++) checkOutput($sformatf("rxWordC%0d", p), int'(rxWords[2][p]), 16'h8001);

        // Start held high: three back-to-back frames on A.
        fallsStart = csFalls[0];
        n = 0;
        while (csFalls[0] < fallsStart + 3 && n < 10000) begin
            applyStimulus(0, 1'b1, randData());
            tick();
            n++;
        end
        if (n >= 10000) checkOutput("backToBackTimeout", 0, 1);
        start[0] = 1'b0;
        checkOutput("backToBackGap", lastGap[0], HP[0] + 1);
        waitIdle(0, 4000, "backToBack");

        // Reset pulse at bit 37, then a clean frame.
        applyStimulus(0, 1'b1, randData());
        tick();
        start[0] = 1'b0;
        n = 0;
        while (rxBitCnt[0] != 37 && n < 4000) begin
            tick();
            n++;
        end
        if (n >= 4000) checkOutput("bit37Timeout", 0, 1);
        doneBefore = doneCnt[0];
        rst[0] = 1'b1;
        tick();
        checkOutput("resetMidFrame", int'({cs[0], sck[0], dat[0], busy[0], done[0]}), 5'b10000);
        rst[0] = 1'b0;
        repeat (40) tick();
        checkOutput("noDoneAfterReset", doneCnt[0], doneBefore);
        rd = randData();
        applyStimulus(0, 1'b1, rd);
        tick();
        start[0] = 1'b0;
        waitIdle(0, 4000, "afterReset");
        checkOutput("csLowAfterReset", csLowLen[0], CSLOW_A);
        sum = 0;
        for (int p = 0; p < NW[0]; p++) begin
            checkOutput($sformatf("rxWordAfterReset%0d", p), int'(rxWords[0][p]), int'(rd[p*WB +: WB]));
            sum = sum + int'(rd[p*WB +: WB]);
        end
        checkOutput("wordCountAfterReset", rxWordCnt[0], NW[0] + CKS);
        for (int p = NW[0]; p < NW[0] + CKS; p++) checkOutput("checksumAfterReset", int'(rxWords[0][p]), sum % 65536);

        // Random traffic: sparse starts, occasional resets, data churning every cycle.
        for (int c = 0; c < 12000; c++) begin
            for (int d = 0; d < 3; d++) begin
                rst[d] = ($urandom_range(0, 4999) == 0);
                applyStimulus(d, $urandom_range(0, 19) == 0, randData());
            end
            tick();
        end
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b0;
            start[d] = 1'b0;
        end
        for (int d = 0; d < 3; d++) waitIdle(d, 4000, "randomDrain");
        repeat (5) tick();

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
